reg_nibble_loader: RTL
======================

// Module: reg_nibble_loader
// PURPOSE
//  Write-side front end for the N-bit enabled register: collects 4-bit nibbles (FPGA switches or
//  a host byte path) MSB-first into an N-bit word, then presents it on a valid/ready handshake.
//  word_load is the single-cycle load pulse that drives the register's enable; word_out drives its data.
//  Sits between the nibble source and the N-bit register.
// PARAMETERS
//  N      64   word width; multiple of 4, N >= 8
//  NIB    N/4  nibbles per word (localparam)
//  CW     $clog2(NIB+1)  nibble counter width (localparam)
// PORTS
//  CLK         in   1     clock, rising edge
//  RN          in   1     asynchronous reset, active-low
//  clr         in   1     synchronous abort: drop partial or held word
//  nib_in      in   4     nibble data
//  nib_valid   in   1     nibble present
//  nib_ready   out  1     loader can accept a nibble
//  word_out    out  N     assembled word; first accepted nibble in [N-1:N-4]
//  word_valid  out  1     word_out complete and stable
//  word_ready  in   1     consumer takes the word
//  word_load   out  1     word_valid & word_ready; register enable pulse
//  nib_cnt     out  CW    nibbles accepted into the current word
//  last_nib    out  4     most recently accepted nibble (display echo)
// BEHAVIOUR
//  - Reset (RN=0): state IDLE; word_out=0, nib_cnt=0, last_nib=0, word_valid=0,
//    nib_ready=0 (registered); nib_ready rises on the first CLK edge after RN releases.
//  - States: IDLE (cnt=0), FILL (0<cnt<NIB), HOLD (word complete).
//  - Accept = nib_valid & nib_ready. On accept: word_out <= {word_out[N-5:0], nib_in};
//    last_nib <= nib_in; nib_cnt++. IDLE->FILL on the first accept.
//  - Accept with nib_cnt==NIB-1: nib_cnt becomes NIB, state HOLD, word_valid=1 and nib_ready=0
//    from the next cycle. No nibble is accepted while in HOLD. nib_cnt never wraps past NIB.
//  - HOLD: word_out and word_valid hold until word_ready. word_valid & word_ready -> word_load=1 for
//    that cycle (combinational), then IDLE next cycle: nib_cnt=0, nib_ready=1, word_valid=0;
//    word_out keeps its value until the next accept. Minimum word period = NIB+1 cycles.
//  - word_ready while word_valid=0: ignored; word_load=0.
//  - nib_valid without nib_ready: ignored; the source holds nib_in until ready.
//  - clr=1 (priority over accept and handshake): next cycle IDLE, nib_cnt=0, word_valid=0,
//    word_out=0, nib_ready=1; word_load is forced to 0 in the clr cycle, so a held word is
//    dropped, never loaded.
//  - RN low mid-word: immediate return to reset values; the partial word is lost.
//  - Latency: last nibble accepted at edge k -> word_valid high after edge k; earliest word_load
//    in the cycle following edge k.
// STRUCTURE
//  - Shared package/include: state encoding (IDLE=2'd0, FILL=2'd1, HOLD=2'd2) and the nibble width
//    constant 4; shared with the register and its reader.
//  - Single module, no sub-module: FSM, nibble counter and shift register are too small to split.
// TESTING
//  1 RN low 3 cycles, then high -> all outputs 0 in reset; nib_ready=1 one edge after release.
//  2 N=16, nibbles A,B,C,D back-to-back, word_ready=1 -> word_out=16'hABCD, word_valid one cycle
//    after D, one word_load pulse, nib_ready=0 that cycle, then 1.
//  3 N=64, 16 nibbles 0..F, word_ready=0 for 5 cycles -> word_out=64'h0123456789ABCDEF held stable;
//    extra nib_valid ignored; nib_cnt=16; word_load only on the ready cycle.
//  4 N=16, 2 nibbles, then clr -> nib_cnt=0, word_out=0; 4 new nibbles 1,2,3,4 -> 16'h1234.
//  5 N=16, HOLD with word_ready=1 and clr=1 in the same cycle -> word_load=0, word dropped,
//    IDLE next cycle.
//  6 N=16, RN pulsed low after 3 nibbles -> immediate reset values; the next 4 nibbles form a
//    clean word; nib_valid toggled randomly -> only handshaked nibbles counted.

Source files
------------

// File: rtl/reg_nibble_loader_pkg.sv
// Shared definitions for the nibble loader, the N-bit register and its reader.
package reg_nibble_loader_pkg;

  // Width of one nibble on the input path
  localparam int unsigned NibW = 4;

  // Loader states; encoding is shared with the register and its reader
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/reg_nibble_loader.sv
// Collects 4-bit nibbles MSB-first into an N-bit word, then offers the word on a valid/ready
// handshake. word_load is the single-cycle enable pulse for the downstream register.
module reg_nibble_loader
  import reg_nibble_loader_pkg::*;
#(
  parameter int unsigned N   = 64,
  localparam int unsigned NIB = N / NibW,
  localparam int unsigned CW  = $clog2(NIB + 1)
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            clr,
  input  logic [NibW-1:0] nib_in,
  input  logic            nib_valid,
  output logic            nib_ready,
  output logic [N-1:0]    word_out,
  output logic            word_valid,
  input  logic            word_ready,
  output logic            word_load,
  output logic [CW-1:0]   nib_cnt,
  output logic [NibW-1:0] last_nib
);

  state_e          r_state, w_state_d;
  logic [N-1:0]    r_word, w_word_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [NibW-1:0] r_last, w_last_d;
  logic            r_nib_ready, w_nib_ready_d;
  logic            w_accept;
  logic            w_last_accept;

  assign w_accept      = nib_valid & r_nib_ready;
  assign w_last_accept = (r_cnt == CW'(NIB - 1));

  // Next-state, datapath updates and handshake outputs; clr overrides accept and handshake
  always_comb begin
    w_state_d = r_state;
    w_word_d  = r_word;
    w_cnt_d   = r_cnt;
    w_last_d  = r_last;
    word_load = 1'b0;
    if (clr) begin
      w_state_d = StIdle;
      w_word_d  = '0;
      w_cnt_d   = '0;
    end else if (w_accept) begin
      w_word_d  = {r_word[N-NibW-1:0], nib_in};
      w_last_d  = nib_in;
      w_cnt_d   = r_cnt + CW'(1);
      w_state_d = w_last_accept ? StHold : StFill;
    end else if (r_state == StHold && word_ready) begin
      word_load = 1'b1;
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end
    // Ready is registered, so it follows the state we are about to enter
    w_nib_ready_d = (w_state_d != StHold);
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state     <= StIdle;
      r_word      <= '0;
      r_cnt       <= '0;
      r_last      <= '0;
      r_nib_ready <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_word      <= w_word_d;
      r_cnt       <= w_cnt_d;
      r_last      <= w_last_d;
      r_nib_ready <= w_nib_ready_d;
    end
  end

  assign nib_ready  = r_nib_ready;
  assign word_out   = r_word;
  assign word_valid = (r_state == StHold);
  assign nib_cnt    = r_cnt;
  assign last_nib   = r_last;

endmodule
